// File: rtl/uart_tx_ctl_module_pkg.sv
// Shared UART definitions: parity mode codes (common with the receive
// controller) and transmit state encodings.
package uart_tx_ctl_module_pkg;

    localparam logic [1:0] NONE_CHECK = 2'd0;
    localparam logic [1:0] ODD_CHECK  = 2'd1;
    localparam logic [1:0] EVEN_CHECK = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_DONE
    } tx_state_t;

    // Mode 3 is reserved and behaves like NONE_CHECK.
    function automatic logic has_parity(input logic [1:0] mode);
        return (mode == ODD_CHECK) || (mode == EVEN_CHECK);
    endfunction

endpackage

// File: rtl/uart_tx_ctl_module.sv
// UART transmit framing controller: start, LSB-first data, optional parity,
// 1/2 stop bits, one bit per Baudclk. Optional line break via UART_TX_BREAK_EN.
//
// state     | meaning
// ST_IDLE   | line high (low while Break), waiting for En && Start
// ST_START  | driving start bit
// ST_DATA   | driving data bit cnt_q
// ST_PARITY | driving parity bit
// ST_STOP1  | driving first stop bit
// ST_STOP2  | driving second stop bit
// ST_DONE   | Doneflg high for this cycle, then back to idle
module uart_tx_ctl_module
    import uart_tx_ctl_module_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       En,
    input  logic       Start,
    input  logic [7:0] Data,
    input  logic [1:0] FrameCheck,
    input  logic       StopBits2,
    input  logic       Baudclk,
`ifdef UART_TX_BREAK_EN
    input  logic       Break,
`endif
    output logic       Enbaud,
    output logic       TX_pin,
    output logic       Busy,
    output logic       Doneflg
);

    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t  state_q, state_d;
    logic       tx_q, tx_d;
    logic       enbaud_q, enbaud_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic       stop2_q, stop2_d;
    logic       par_q, par_d;
    logic       brk;
    logic [7:0] data_m;

`ifdef UART_TX_BREAK_EN
    assign brk = Break;
`else
    assign brk = 1'b0;
`endif

    assign data_m = Data & DATA_MASK;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            tx_q     <= 1'b1;
            enbaud_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            shift_q  <= '0;
            cnt_q    <= '0;
            mode_q   <= NONE_CHECK;
            stop2_q  <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            enbaud_q <= enbaud_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            stop2_q  <= stop2_d;
            par_q    <= par_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        enbaud_d = enbaud_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        stop2_d  = stop2_q;
        par_d    = par_q;

        case (state_q)
            ST_IDLE: begin
                tx_d     = ~brk;
                enbaud_d = 1'b0;
                busy_d   = 1'b0;
                if (En && Start && !brk) begin
                    shift_d  = data_m;
                    mode_d   = FrameCheck;
                    stop2_d  = StopBits2;
                    par_d    = (FrameCheck == ODD_CHECK) ? ~(^data_m) : ^data_m;
                    tx_d     = 1'b0;
                    enbaud_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (Baudclk) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (Baudclk) begin
                    if (cnt_q < LAST_BIT) begin
                        cnt_d   = cnt_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end else if (has_parity(mode_q)) begin
                        tx_d    = par_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP1;
                    end
                end
            end
            ST_PARITY: begin
                if (Baudclk) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (Baudclk) begin
                    if (stop2_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        enbaud_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_STOP2: begin
                if (Baudclk) begin
                    enbaud_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                tx_d     = 1'b1;
                enbaud_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    assign Enbaud  = enbaud_q;
    assign TX_pin  = tx_q;
    assign Busy    = busy_q;
    assign Doneflg = done_q;

endmodule

// File: tb/tb_uart_tx_ctl_module.sv
// Self-checking bench for uart_tx_ctl_module: frame vector table, bit
// scoreboard fed at Start and drained at each Baudclk, corner sequences.
module tb_uart_tx_ctl_module;

    localparam int DIV = 8;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       En = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] Data = 8'h00;
    logic [1:0] FrameCheck = 2'd0;
    logic       StopBits2 = 1'b0;
    logic       Baudclk = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic       Break = 1'b0;
`endif
    logic       Enbaud, TX_pin, Busy, Doneflg;

    uart_tx_ctl_module #(.DATA_BITS(8)) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .En(En),
        .Start(Start),
        .Data(Data),
        .FrameCheck(FrameCheck),
        .StopBits2(StopBits2),
        .Baudclk(Baudclk),
`ifdef UART_TX_BREAK_EN
        .Break(Break),
`endif
        .Enbaud(Enbaud),
        .TX_pin(TX_pin),
        .Busy(Busy),
        .Doneflg(Doneflg)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  fc;
        logic        s2;
        logic [11:0] exp_bits;   // bit i = i-th bit on the line
        int          exp_len;
    } vec_t;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit sb_q[$];
    bit exp_b;
    int pulses = 0;
    int done_cnt = 0;
    int bcnt = 0;
    bit baud_force = 1'b0;

    // Baud generator model; each pulse closes a bit period, so TX_pin is
    // checked against the scoreboard right as the pulse is issued.
    always @(negedge CLK) begin
        if (Doneflg) done_cnt++;
        if (Enbaud && RSTn) begin
            if (bcnt == DIV - 1) begin
                bcnt = 0;
                Baudclk = 1'b1;
                pulses++;
                vec_cnt++;
                if (sb_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL bit_extra: TX_pin=%0b at pulse %0d, no bit expected", TX_pin, pulses);
                end else begin
                    exp_b = sb_q.pop_front();
                    if (TX_pin !== exp_b) begin
                        err_cnt++;
                        $display("FAIL line_bit: pulse %0d TX_pin=%0b expected %0b", pulses, TX_pin, exp_b);
                    end
                end
            end else begin
                bcnt++;
                Baudclk = baud_force;
            end
        end else begin
            bcnt = 0;
            Baudclk = baud_force;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input logic [1:0] fc, input logic s2,
                               input logic [11:0] bits, input int len);
        @(negedge CLK);
        for (int i = 0; i < len; i++) sb_q.push_back(bits[i]);
        pulses = 0;
        Data = d;
        FrameCheck = fc;
        StopBits2 = s2;
        En = 1'b1;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        chk("accept_busy", 32'(Busy), 1);
        chk("accept_enbaud", 32'(Enbaud), 1);
        chk("accept_tx_start", 32'(TX_pin), 0);
    endtask

    task automatic finish_frame(input int len);
        int d0 = done_cnt;
        int n = 0;
        while (Busy && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk("frame_end_busy", 32'(Busy), 0);
        chk("done_pulses", 32'(done_cnt - d0), 1);
        chk("frame_len", 32'(pulses), 32'(len));
        chk("sb_empty", 32'(sb_q.size()), 0);
        chk("enbaud_off", 32'(Enbaud), 0);
        chk("tx_idle_high", 32'(TX_pin), 1);
        sb_q.delete();
    endtask

    task automatic wait_pulses(input int n);
        int c = 0;
        while (pulses < n && c < 2000) begin
            @(negedge CLK);
            c++;
        end
        chk("pulse_wait", 32'(pulses >= n), 1);
    endtask

    vec_t vt[7];
    int   d0;
    int   bad;

    initial begin
        vt[0] = '{8'h55, 2'd0, 1'b0, 12'h2AA, 10};
        vt[1] = '{8'hA3, 2'd2, 1'b0, 12'h546, 11};
        vt[2] = '{8'hA3, 2'd1, 1'b0, 12'h746, 11};
        vt[3] = '{8'h00, 2'd0, 1'b1, 12'h600, 11};
        vt[4] = '{8'hFF, 2'd2, 1'b1, 12'hDFE, 12};
        vt[5] = '{8'h12, 2'd3, 1'b0, 12'h224, 10};
        vt[6] = '{8'h80, 2'd1, 1'b0, 12'h500, 11};

        repeat (3) @(negedge CLK);
        chk("rst_tx", 32'(TX_pin), 1);
        chk("rst_enbaud", 32'(Enbaud), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Doneflg), 0);
        RSTn = 1'b1;
        @(negedge CLK);

        // Baudclk in IDLE and Start without En must do nothing
        baud_force = 1'b1;
        repeat (4) @(negedge CLK);
        baud_force = 1'b0;
        chk("idle_baud_tx", 32'(TX_pin), 1);
        chk("idle_baud_busy", 32'(Busy), 0);
        En = 1'b0;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        chk("no_en_busy", 32'(Busy), 0);
        chk("no_en_enbaud", 32'(Enbaud), 0);

        for (int v = 0; v < 7; v++) begin
            start_frame(vt[v].data, vt[v].fc, vt[v].s2, vt[v].exp_bits, vt[v].exp_len);
            finish_frame(vt[v].exp_len);
        end

        // Restart attempt and config changes mid-frame, then En drop
        start_frame(8'h12, 2'd0, 1'b0, 12'h224, 10);
        wait_pulses(3);
        Data = 8'hFF;
        FrameCheck = 2'd2;
        StopBits2 = 1'b1;
        Start = 1'b1;
        repeat (2) @(negedge CLK);
        Start = 1'b0;
        En = 1'b0;
        finish_frame(10);
        repeat (5) @(negedge CLK);
        chk("no_queued_frame", 32'(Busy), 0);
        En = 1'b1;

        // Reset during data bit 4
        start_frame(8'h00, 2'd0, 1'b0, 12'h200, 10);
        wait_pulses(5);
        repeat (2) @(negedge CLK);
        d0 = done_cnt;
        RSTn = 1'b0;
        #1;
        chk("midrst_tx", 32'(TX_pin), 1);
        chk("midrst_enbaud", 32'(Enbaud), 0);
        chk("midrst_busy", 32'(Busy), 0);
        sb_q.delete();
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        chk("midrst_no_done", 32'(done_cnt - d0), 0);
        start_frame(8'h55, 2'd0, 1'b0, 12'h2AA, 10);
        finish_frame(10);

`ifdef UART_TX_BREAK_EN
        Break = 1'b1;
        @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge CLK);
            if (TX_pin !== 1'b0 || Busy !== 1'b0) bad++;
        end
        chk("break_hold", 32'(bad), 0);
        Break = 1'b0;
        @(negedge CLK);
        chk("break_release_tx", 32'(TX_pin), 1);
        chk("break_release_busy", 32'(Busy), 0);

        start_frame(8'h55, 2'd0, 1'b0, 12'h2AA, 10);
        wait_pulses(3);
        Break = 1'b1;
        finish_frame(10);
        @(negedge CLK);
        chk("break_after_frame", 32'(TX_pin), 0);
        Break = 1'b0;
        @(negedge CLK);
        chk("break_after_release", 32'(TX_pin), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
